// File: rtl/cache_types_pkg.sv
// Shared cache-control types: PLRU state-vector typedef and the PLRU flush FSM states.
package cache_types_pkg;

    // Default cache geometry. plru_bits_t is the per-set tree vector at that geometry.
    localparam int PLRU_WAYS = 8;
    typedef logic [PLRU_WAYS-2:0] plru_bits_t;

    typedef enum logic {
        PLRU_IDLE  = 1'b0,
        PLRU_FLUSH = 1'b1
    } plru_state_t;

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper: next-bits for a touched way, and the victim walk of the input bits.
module plru_tree #(
    parameter int WAYS  = 8,
    parameter int W_IDX = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  bits_in,
    input  logic [W_IDX-1:0] upd_way,
    output logic [WAYS-2:0]  bits_next,
    output logic [W_IDX-1:0] victim
);

    logic [W_IDX:0] upd_node;
    logic [W_IDX:0] walk_node;

    // Heap order: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
    always_comb begin
        bits_next = bits_in;
        upd_node  = '0;
        for (int d = 0; d < W_IDX; d++) begin
            bits_next[upd_node[W_IDX-1:0]] = ~upd_way[W_IDX-1-d];
            upd_node = {upd_node[W_IDX-1:0], 1'b0}
                     + (W_IDX+1)'(upd_way[W_IDX-1-d])
                     + (W_IDX+1)'(1);
        end
    end

    always_comb begin
        victim    = '0;
        walk_node = '0;
        for (int d = 0; d < W_IDX; d++) begin
            victim[W_IDX-1-d] = bits_in[walk_node[W_IDX-1:0]];
            walk_node = {walk_node[W_IDX-1:0], 1'b0}
                      + (W_IDX+1)'(victim[W_IDX-1-d])
                      + (W_IDX+1)'(1);
        end
    end

endmodule

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU store with registered victim lookup and sequenced flush.
// Optional PLRU_BYPASS_EN: same-set access/lookup collisions walk the post-update bits.
module plru_array
    import cache_types_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int SETS  = 16,
    parameter int W_IDX = $clog2(WAYS),
    parameter int S_IDX = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_valid,
    input  logic [S_IDX-1:0] acc_set,
    input  logic [W_IDX-1:0] acc_way,
    input  logic             vict_req,
    input  logic [S_IDX-1:0] vict_set,
    output logic             vict_valid,
    output logic [W_IDX-1:0] vict_way,
    input  logic             flush_req,
    output logic             flush_busy
);

    logic [WAYS-2:0]  plru_mem [SETS];
    logic [WAYS-2:0]  upd_next;
    logic [WAYS-2:0]  walk_bits;
    logic [W_IDX-1:0] walk_way;
    logic [W_IDX-1:0] upd_victim_unused;
    logic [WAYS-2:0]  walk_next_unused;

    plru_state_t      state_q, state_d;
    logic [S_IDX-1:0] flush_cnt_q, flush_cnt_d;
    logic             acc_en, vict_en;

    // A flush request wins over accesses and lookups in the same idle cycle.
    assign acc_en     = (state_q == PLRU_IDLE) && acc_valid && !flush_req;
    assign vict_en    = (state_q == PLRU_IDLE) && vict_req && !flush_req;
    assign flush_busy = (state_q == PLRU_FLUSH);

    plru_tree #(.WAYS(WAYS), .W_IDX(W_IDX)) u_tree_upd (
        .bits_in   (plru_mem[acc_set]),
        .upd_way   (acc_way),
        .bits_next (upd_next),
        .victim    (upd_victim_unused)
    );

`ifdef PLRU_BYPASS_EN
    assign walk_bits = (acc_en && (acc_set == vict_set)) ? upd_next : plru_mem[vict_set];
`else
    assign walk_bits = plru_mem[vict_set];
`endif

    plru_tree #(.WAYS(WAYS), .W_IDX(W_IDX)) u_tree_walk (
        .bits_in   (walk_bits),
        .upd_way   (acc_way),
        .bits_next (walk_next_unused),
        .victim    (walk_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLRU_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            PLRU_IDLE: begin
                if (flush_req) begin
                    state_d     = PLRU_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            PLRU_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == S_IDX'(SETS-1)) begin
                    state_d     = PLRU_IDLE;
                    flush_cnt_d = '0;
                end
            end
            default: state_d = PLRU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) plru_mem[s] <= '0;
        end else if (state_q == PLRU_FLUSH) begin
            plru_mem[flush_cnt_q] <= '0;
        end else if (acc_en) begin
            plru_mem[acc_set] <= upd_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vict_valid <= 1'b0;
            vict_way   <= '0;
        end else begin
            vict_valid <= vict_en;
            if (vict_en) vict_way <= walk_way;
        end
    end

endmodule

// File: tb/tb_plru_array.sv
// Self-checking bench for plru_array: vector table, flush/reset sequences, randomized model phase.
module tb_plru_array;

    localparam int WAYS  = 8;
    localparam int SETS  = 16;
    localparam int W_IDX = 3;
    localparam int S_IDX = 4;

`ifdef PLRU_BYPASS_EN
    localparam int COLL_EXP = 4;
`else
    localparam int COLL_EXP = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             acc_valid;
    logic [S_IDX-1:0] acc_set;
    logic [W_IDX-1:0] acc_way;
    logic             vict_req;
    logic [S_IDX-1:0] vict_set;
    logic             vict_valid;
    logic [W_IDX-1:0] vict_way;
    logic             flush_req;
    logic             flush_busy;

    plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_valid  (acc_valid),
        .acc_set    (acc_set),
        .acc_way    (acc_way),
        .vict_req   (vict_req),
        .vict_set   (vict_set),
        .vict_valid (vict_valid),
        .vict_way   (vict_way),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit av;
        int as;
        int aw;
        bit vr;
        int vs;
        int exp;
    } vec_t;

    int       checks   = 0;
    int       failures = 0;
    int       sb_q[$];
    vec_t     tbl[$];
    logic [WAYS-2:0] mdl [SETS];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge against the scoreboard.
    task automatic cyc();
        int e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("vict_valid", int'(vict_valid), 1);
            check("vict_way", int'(vict_way), e);
        end else begin
            check("vict_valid_idle", int'(vict_valid), 0);
        end
    endtask

    task automatic idle_inputs();
        acc_valid = 1'b0;
        acc_set   = '0;
        acc_way   = '0;
        vict_req  = 1'b0;
        vict_set  = '0;
        flush_req = 1'b0;
    endtask

    task automatic drive(bit av, int as, int aw, bit vr, int vs, int exp);
        acc_valid = av;
        acc_set   = S_IDX'(as);
        acc_way   = W_IDX'(aw);
        vict_req  = vr;
        vict_set  = S_IDX'(vs);
        if (vr) sb_q.push_back(exp);
    endtask

    // Reference model in closed form: depth-d node on the path to way w is (2^d - 1) + (w >> (W_IDX-d)).
    function automatic logic [WAYS-2:0] mdl_touch(logic [WAYS-2:0] b, int way);
        for (int d = 0; d < W_IDX; d++) begin
            int n;
            n = (1 << d) - 1 + (way >> (W_IDX - d));
            b[n] = (((way >> (W_IDX - 1 - d)) & 1) == 0);
        end
        return b;
    endfunction

    function automatic int mdl_victim(logic [WAYS-2:0] b);
        int p;
        p = 0;
        for (int d = 0; d < W_IDX; d++) begin
            int n;
            n = (1 << d) - 1 + p;
            p = p * 2 + int'(b[n]);
        end
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int n;
        logic [WAYS-2:0] b;
        int av, as, aw, vr, vs, e;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vict_valid", int'(vict_valid), 0);
        check("rst_vict_way", int'(vict_way), 0);
        check("rst_flush_busy", int'(flush_busy), 0);
        rst_n = 1'b1;

        // Vector table: one row per cycle.
        tbl.push_back('{0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 3, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 3, 4});
        for (int w = 0; w < WAYS; w++) tbl.push_back('{1, 5, w, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 5, 0});
        tbl.push_back('{0, 0, 0, 1, 4, 0});
        tbl.push_back('{1, 2, 0, 1, 2, COLL_EXP});
        tbl.push_back('{0, 0, 0, 1, 2, 4});
        tbl.push_back('{1, 9, 1, 1, 3, 4});
        tbl.push_back('{0, 0, 0, 1, 9, 4});
        tbl.push_back('{0, 0, 0, 0, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].av, tbl[i].as, tbl[i].aw, tbl[i].vr, tbl[i].vs, tbl[i].exp);
            cyc();
        end
        idle_inputs();

        // Load set 7 with ways 0..3, then flush with traffic during the flush.
        for (int w = 0; w < 4; w++) begin
            drive(1, 7, w, 0, 0, 0);
            cyc();
        end
        drive(0, 0, 0, 1, 7, 4);
        cyc();
        idle_inputs();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        busy = 0;
        n = 0;
        while (flush_busy && n < 2 * SETS) begin
            busy++;
            acc_valid = 1'b1; acc_set = 7; acc_way = 4;
            vict_req  = 1'b1; vict_set = 7;
            flush_req = (n == 3);
            cyc();
            n++;
        end
        idle_inputs();
        check("flush_len", busy, SETS);
        drive(0, 0, 0, 1, 7, 0); cyc();
        drive(0, 0, 0, 1, 3, 0); cyc();
        drive(0, 0, 0, 1, 9, 0); cyc();
        idle_inputs();

        // Reset asserted mid-flush: set 12 is not yet cleared by the flush at that point.
        drive(1, 12, 0, 0, 0, 0);
        cyc();
        idle_inputs();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        repeat (4) cyc();
        check("busy_before_rst", int'(flush_busy), 1);
        rst_n = 1'b0;
        #2;
        check("rst_mid_busy", int'(flush_busy), 0);
        check("rst_mid_valid", int'(vict_valid), 0);
        @(posedge clk);
        #1;
        check("rst_hold_busy", int'(flush_busy), 0);
        rst_n = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            drive(0, 0, 0, 1, s, 0);
            cyc();
        end
        idle_inputs();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        busy = 0;
        n = 0;
        while (flush_busy && n < 2 * SETS) begin
            busy++;
            cyc();
            n++;
        end
        check("flush2_len", busy, SETS);

        // Randomized phase against the reference model (array is all-zero here).
        for (int s = 0; s < SETS; s++) mdl[s] = '0;
        for (int i = 0; i < 300; i++) begin
            av = int'($urandom_range(0, 1));
            as = int'($urandom_range(0, SETS - 1));
            aw = int'($urandom_range(0, WAYS - 1));
            vr = int'($urandom_range(0, 1));
            vs = ($urandom_range(0, 3) == 0) ? as : int'($urandom_range(0, SETS - 1));
            b = mdl[vs];
`ifdef PLRU_BYPASS_EN
            if (av != 0 && as == vs) b = mdl_touch(mdl[as], aw);
`endif
            e = mdl_victim(b);
            if (av != 0) mdl[as] = mdl_touch(mdl[as], aw);
            drive(av != 0, as, aw, vr != 0, vs, e);
            cyc();
        end
        idle_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plru_array.md
# plru_array

Per-set tree pseudo-LRU state store for an N-way set-associative cache; generalises the fixed 8-way combinational PLRU update into a parametrised, registered array covering every set. It sits beside the tag/valid arrays in the I- and D-cache control paths. It does three things:
- Absorbs hit/fill accesses to update replacement state.
- Returns a registered victim way for a requested set.
- Supports a multi-cycle sequenced flush of all state.

## Interface
- WAYS, 8: associativity; power of two, ≥2; tree has WAYS-1 bits per set
- SETS, 16: number of sets; power of two, ≥2
- W_IDX, $clog2(WAYS): derived way-index width
- S_IDX, $clog2(SETS): derived set-index width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- acc_valid  in  1  hit or fill touched a way this cycle
- acc_set  in  S_IDX  set of access
- acc_way  in  W_IDX  way touched
- vict_req  in  1  victim lookup request
- vict_set  in  S_IDX  set to look up
- vict_valid  out  1  victim_way valid (one-cycle pulse)
- vict_way  out  W_IDX  selected victim, registered
- flush_req  in  1  start a flush of all PLRU state (pulse)
- flush_busy  out  1  flush in progress

## Operation
- Tree bit layout is heap-ordered: node i has children 2i+1 (lower half of ways) and 2i+2 (upper half). Node 0 is the root; the leaf-level nodes select between way pairs.
- Update on acc_valid: for each tree level d (0 = root), the node on the path to acc_way is written with ~acc_way[W_IDX-1-d]. All other bits are unchanged. The new bits are stored at the next rising edge.
- Victim walk: start at the root. Bit 0 descends to the left child, bit 1 to the right child. The sequence of chosen bits, MSB first, forms vict_way.
- FSM with two states, IDLE and FLUSH.
  - IDLE → FLUSH when flush_req is asserted. The flush counter loads 0.
  - In FLUSH, one set is cleared to all-zero per cycle, and the counter increments.
  - FLUSH → IDLE after set SETS-1 is cleared, so FLUSH lasts exactly SETS cycles.
  - flush_busy is asserted only while in FLUSH.
- While in FLUSH:
  - acc_valid is ignored.
  - vict_req is ignored, and vict_valid stays 0.
  - flush_req is ignored; no restart occurs.
- flush_req and acc_valid in the same IDLE cycle: the access is dropped and the flush starts.
- acc_valid and vict_req to different sets in the same cycle: both are serviced independently.
- Reset (async, any state):
  - All tree bits are 0.
  - State returns to IDLE and the counter to 0.
  - vict_valid=0, vict_way=0, flush_busy=0.
  - Assertion mid-flush aborts the flush; the array is cleared by reset anyway.

## Timing
- Update latency: an access at cycle t is visible in the stored bits from cycle t+1.
- Victim latency: a request at cycle t produces vict_valid=1 and vict_way at cycle t+1, both registered. vict_valid is 0 in any cycle not following an accepted request.
- Back-to-back victim requests are accepted every cycle.
- Same-set collision (acc_valid and vict_req to one set in cycle t): the behaviour is set by the configuration macro below.
- An access at t with a request for the same set at t+1 always sees the updated bits.
- Flush: flush_req at t gives flush_busy=1 in cycles t+1 … t+SETS. New accesses and requests are accepted from cycle t+SETS+1.

## Configuration
- PLRU_BYPASS_EN defined: on a same-set collision, the victim walk uses the post-update bits. The touched way is therefore never returned as victim in that case.
- PLRU_BYPASS_EN undefined: the victim walk uses the stored (pre-update) bits. This is cheaper, and the victim may equal the way just touched.

## Structure
- Shared cache package (cache_types_pkg) holds:
  - a plru_bits_t typedef parameterised by WAYS;
  - the state enum (PLRU_IDLE, PLRU_FLUSH).
- Sub-module plru_tree: purely combinational, parametrised by WAYS. It provides next-bits(update) and victim(walk) functions. plru_array instantiates it twice, once on the update path and once on the victim path.

## Test plan
- Reset, then vict_req on set 0 → next cycle vict_valid=1, vict_way=0.
- WAYS=8: acc_valid, set 3, way 0 → set 3 bits = 7'b0001011. vict_req on set 3 the following cycle → vict_way=4.
- WAYS=8: accesses to ways 0,1,…,7 in successive cycles on set 5, then vict_req on set 5 → vict_way=0. Set 4 victim remains 0.
- Same cycle: acc set 2 way 0 and vict_req set 2, from reset state → vict_way=4 with PLRU_BYPASS_EN, vict_way=0 without.
- Load set 7 (ways 0–3 touched), pulse flush_req:
  - flush_busy is high for exactly SETS cycles.
  - acc_valid and vict_req during flush have no effect (vict_valid=0).
  - Afterwards, vict_req on set 7 → 0.
- Assert rst_n=0 mid-flush (cycle 5) → flush_busy=0 immediately. After release, all sets return victim 0 and a new flush_req is accepted.
